serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add or subtract by streaming operands LSB-first through a one-bit full-adder stage.
- The full-adder stage has a registered sum bit and a registered carry.
- The controller owns the following: operand shift registers, carry flip-flop, bit counter, result shift register and start/busy/done handshake.
- It sits between a parallel requester (ALU front-end or testbench) and the bit-serial datapath, and trades area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add (a+b+c_in); 1 = subtract (a+~b+1), c_in ignored.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- c_in  input  1  carry-in for add mode; captured on the accepted start edge.
- sum  output  WIDTH  result; held from DONE until the next accepted start.
- c_out  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - sum, c_out, ovf, busy, done, count, shift registers and carry all = 0.
  - Takes effect immediately, including mid-RUN; the partial result is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: A_sr<=a; B_sr<=(sub ? ~b : b); carry<=(sub ? 1 : c_in); count<=0; state<=RUN.
  - sum/c_out/ovf keep their previous values until that edge, then sum<=0.
  - start=0: stay in IDLE.
- RUN, per edge:
  - s = A_sr[0]^B_sr[0]^carry.
  - carry <= (A_sr[0]&B_sr[0]) | ((A_sr[0]^B_sr[0])&carry).
  - sum shift register shifts right, inserting s at the MSB.
  - A_sr and B_sr shift right.
  - count increments.
  - On the edge where count == WIDTH-1:
    - record carry-into-MSB = the carry value before this edge.
    - state<=DONE.
    - c_out<=new carry.
    - ovf<=old carry XOR new carry.
- RUN has exactly WIDTH cycles; busy=1 throughout. start, sub, a, b and c_in are ignored while busy.
- DONE:
  - lasts exactly 1 cycle; done=1, busy=0; sum, c_out and ovf are valid.
  - next edge goes unconditionally to IDLE; start is not sampled in DONE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+WIDTH, i.e. (WIDTH+1) cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- Arithmetic: modulo 2^WIDTH; no saturation. c_out and ovf are always computed in both modes.
- The counter never exceeds WIDTH-1. Its wrap to 0 occurs only via the IDLE load.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C, c_in=0, start for 1 cycle → busy high exactly 8 cycles; done pulse on cycle 9 after acceptance; sum=0x96, c_out=0, ovf=1.
- Add, a=0xFF, b=0x01, c_in=1 → sum=0x01, c_out=1, ovf=0. Then sub=1, a=0x10, b=0x20, c_in=1 (ignored) → sum=0xF0, c_out=0, ovf=0.
- Sub, a=0x80, b=0x01 → sum=0x7F, c_out=1, ovf=1. Outputs hold these values for 5 idle cycles after done.
- start held high with operands changed every cycle → only the values present at each IDLE-acceptance edge are used; done pulses every 10 cycles; mid-RUN operand changes do not affect the result.
- Assert rst_n=0 asynchronously (between clock edges) at RUN cycle 4 → state, busy and all outputs 0 immediately. Release rst_n and wait 12 cycles with start=0 → no done pulse. Then a new add 0x01+0x01 → sum=0x02.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencer.
// Operands are loaded in parallel and then streamed LSB-first through a
// single full-adder bit with a registered carry. One bit is processed per
// cycle, so an operation occupies the datapath for WIDTH cycles.

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             bit_sum;
    logic             bit_carry;

    // Next-state logic: operand load in IDLE, one full-adder step per RUN cycle,
    // and capture of carry-out/overflow on the final bit.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_d     = sum_q;
        count_d   = count_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        bit_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        bit_carry = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so invert B and force the carry-in.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = bit_carry;
                if (count_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB; bit_carry is the carry out.
                    c_out_d = bit_carry;
                    ovf_d   = carry_q ^ bit_carry;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8). Directed operations push their
// hand-computed results into a scoreboard queue; a monitor pops and compares
// each time the DUT raises done.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;
    logic         done;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point so every check is counted the same way.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.sum));
                checkOutput("c_out", 32'(c_out), 32'(e.c_out));
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Issue one operation from IDLE, then wait (bounded) for its done pulse,
    // checking latency and the number of busy cycles along the way.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic op_cin, input logic op_sub,
                                 input logic [W-1:0] exp_sum, input logic exp_cout,
                                 input logic exp_ovf);
        int  cycles;
        int  busy_cycles;
        bit  got_done;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        c_in  = op_cin;
        sub   = op_sub;
        start = 1'b1;
        exp_q.push_back('{sum: exp_sum, c_out: exp_cout, ovf: exp_ovf});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~op_a;
        b     = ~op_b;
        c_in  = ~op_cin;
        sub   = ~op_sub;
        cycles = 0;
        busy_cycles = 0;
        got_done = 1'b0;
        while (!got_done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            if (done) got_done = 1'b1;
        end
        if (!got_done) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(cycles), 32'd9);
            checkOutput("busy_cycles", 32'(busy_cycles), 32'd8);
            checkOutput("busy_in_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ka;
        logic [W-1:0] kb;
        int           done_seen;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Basic add, add with carry wrap, subtract with borrow, subtract with overflow.
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Results hold while idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_sum", 32'(sum), 32'h7F);
            checkOutput("hold_c_out", 32'(c_out), 32'd1);
            checkOutput("hold_ovf", 32'(ovf), 32'd1);
            checkOutput("hold_done", 32'(done), 32'd0);
        end

        // Start held high with operands changing every cycle. Acceptance edges
        // are k=0,10,20: (01+02)=03, (1F+34)=53, (3D+66)=A3 with signed overflow.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput("held_done", 32'(done), 32'((k % 10) == 9));
            ka    = 8'(k * 3 + 1);
            kb    = 8'(k * 5 + 2);
            a     = ka;
            b     = kb;
            c_in  = k[0];
            sub   = ((k % 10) != 0);
            start = 1'b1;
            if (k == 0)  exp_q.push_back('{sum: 8'h03, c_out: 1'b0, ovf: 1'b0});
            if (k == 10) exp_q.push_back('{sum: 8'h53, c_out: 1'b0, ovf: 1'b0});
            if (k == 20) exp_q.push_back('{sum: 8'hA3, c_out: 1'b0, ovf: 1'b1});
        end
        @(negedge clk);
        start = 1'b0;
        sub   = 1'b0;
        checkOutput("held_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of RUN discards the operation.
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h44;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_c_out", 32'(c_out), 32'd0);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("no_done_after_abort", 32'(done_seen), 32'd0);

        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        @(negedge clk);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
